// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared widths, reset PC, fetch FSM states and instruction field helpers
package cpu_fetch_pkg;

    localparam int ADDR_W = 16;
    localparam int INSTR_W = 26;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    localparam int OPCODE_MSB = 25;
    localparam int OPCODE_LSB = 22;
    localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - memory request/response, redirect and instruction output bundle
interface instruction_fetch_unit_if #(
    parameter int ADDR_W  = cpu_fetch_pkg::ADDR_W,
    parameter int INSTR_W = cpu_fetch_pkg::INSTR_W
);

    logic               memReqValid;
    logic               memReqReady;
    logic [ADDR_W-1:0]  memReqAddr;
    logic               memRespValid;
    logic [INSTR_W-1:0] memRespData;
    logic               redirectValid;
    logic [ADDR_W-1:0]  redirectAddr;
    logic               halt;
    logic               instrValid;
    logic               instrReady;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  instrAddr;

    modport master (
        output memReqValid, memReqAddr, instrValid, instruction, instrAddr,
        input  memReqReady, memRespValid, memRespData, redirectValid, redirectAddr,
               halt, instrReady
    );

    modport slave (
        input  memReqValid, memReqAddr, instrValid, instruction, instrAddr,
        output memReqReady, memRespValid, memRespData, redirectValid, redirectAddr,
               halt, instrReady
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, power-of-two depth, no bypass
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC, credit-limited memory requests, prefetch buffer and redirect flush
module instruction_fetch_unit #(
    parameter int                ADDR_W   = cpu_fetch_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_fetch_pkg::INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_fetch_pkg::RESET_PC
) (
    input  logic                     clock,
    input  logic                     resetN,
    instruction_fetch_unit_if.master bus
);

    import cpu_fetch_pkg::*;

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  tag_head;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   discard_cnt;
    logic [CNT_W-1:0]   discard_load;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   tag_count;
    logic [ENTRY_W-1:0] entry_head;
    logic               redirect;
    logic               resp;
    logic               req_valid;
    logic               req_fire;
    logic               keep_resp;
    logic               instr_valid;
    logic               pop;

    assign redirect = bus.redirectValid;
    assign resp     = bus.memRespValid;

    // In-flight plus buffered never exceeds DEPTH, so every response has a slot.
    assign req_valid = resetN && !redirect && !bus.halt &&
                       ((CNT_W+1)'(outstanding) + (CNT_W+1)'(count) < (CNT_W+1)'(DEPTH));
    assign req_fire  = req_valid && bus.memReqReady;

    assign keep_resp    = resp && !redirect && (discard_cnt == '0) && (tag_count != '0);
    assign discard_load = outstanding - CNT_W'(resp);

    assign instr_valid = (count != '0) && !redirect;
    assign pop         = instr_valid && bus.instrReady;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (redirect && discard_load != '0) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    state_next = (discard_load != '0) ? FLUSH : RUN;
                end else if (resp && discard_cnt == CNT_W'(1)) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // A response landing in the redirect cycle belongs to the old path and is dropped too.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else if (redirect) begin
            fetch_pc    <= bus.redirectAddr;
            outstanding <= discard_load;
            discard_cnt <= discard_load;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp);
            if (resp && discard_cnt != '0) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
        .clock     (clock),
        .resetN    (resetN),
        .flush     (redirect),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (keep_resp),
        .head      (tag_head),
        .count     (tag_count)
    );

    fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_instr_q (
        .clock     (clock),
        .resetN    (resetN),
        .flush     (redirect),
        .push      (keep_resp),
        .push_data ({tag_head, bus.memRespData}),
        .pop       (pop),
        .head      (entry_head),
        .count     (count)
    );

    assign bus.memReqValid = req_valid;
    assign bus.memReqAddr  = fetch_pc;
    assign bus.instrValid  = instr_valid;
    assign bus.instruction = entry_head[INSTR_W-1:0];
    assign bus.instrAddr   = entry_head[ENTRY_W-1:INSTR_W];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed stimulus with memory model and scoreboard monitor
module tb_instruction_fetch_unit;

    import cpu_fetch_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] word;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } pend_t;

    logic clock = 1'b0;
    logic resetN;

    always #5 clock = ~clock;

    instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    instruction_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    int fires = 0;
    int pops = 0;
    exp_t exp_q[$];
    pend_t pend_q[$];
    logic [ADDR_W-1:0] model_pc;
    logic [ADDR_W-1:0] wrap_addrs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {~a[9:0], a};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick();
        tick();
    endtask

    // Instruction memory: in-order, fixed latency, no backpressure.
    initial begin
        bus.memRespValid = 1'b0;
        bus.memRespData  = '0;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.memRespValid = 1'b1;
                bus.memRespData  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                bus.memRespValid = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (!resetN) begin
                exp_q.delete();
                pend_q.delete();
                model_pc = RESET_PC;
            end else begin
                if (bus.redirectValid) begin
                    exp_q.delete();
                    model_pc = bus.redirectAddr;
                end
                if (bus.instrValid && bus.instrReady) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow actual=addr %0h required=no instruction", bus.instrAddr);
                    end else begin
                        e = exp_q.pop_front();
                        check("instr_addr", 32'(bus.instrAddr), 32'(e.addr));
                        check("instruction", 32'(bus.instruction), 32'(e.word));
                        pops++;
                    end
                end
                if (bus.memReqValid && bus.memReqReady) begin
                    check("req_addr", 32'(bus.memReqAddr), 32'(model_pc));
                    exp_q.push_back('{model_pc, mem_word(model_pc)});
                    pend_q.push_back('{bus.memReqAddr, cyc + mem_lat});
                    model_pc = model_pc + 16'd1;
                    fires++;
                end
            end
        end
    end

    initial begin
        int start;
        resetN            = 1'b0;
        bus.memReqReady   = 1'b0;
        bus.redirectValid = 1'b0;
        bus.redirectAddr  = '0;
        bus.halt          = 1'b0;
        bus.instrReady    = 1'b0;
        wrap_addrs        = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

        repeat (2) sample();
        check("rst_req_valid", 32'(bus.memReqValid), 32'd0);
        check("rst_req_addr", 32'(bus.memReqAddr), 32'(RESET_PC));
        check("rst_instr_valid", 32'(bus.instrValid), 32'd0);
        check("rst_instruction", 32'(bus.instruction), 32'd0);
        check("rst_instr_addr", 32'(bus.instrAddr), 32'd0);

        // Streaming with 1-cycle memory: back-to-back requests, data at accept+2.
        tick();
        resetN = 1'b1;
        bus.memReqReady = 1'b1;
        bus.instrReady = 1'b1;
        mem_lat = 1;
        for (int i = 0; i < 8; i++) begin
            sample();
            check("stream_req_valid", 32'(bus.memReqValid), 32'd1);
            check("stream_req_addr", 32'(bus.memReqAddr), 32'(i));
            check("stream_instr_valid", 32'(bus.instrValid), 32'(i >= 2));
            tick();
        end

        // Consumer stalled: credits cap requests at DEPTH, each pop frees one.
        do_reset();
        bus.instrReady = 1'b0;
        start = fires;
        resetN = 1'b1;
        repeat (10) begin
            sample();
            tick();
        end
        check("credit_fires", 32'(fires - start), 32'd4);
        sample();
        check("credit_req_valid", 32'(bus.memReqValid), 32'd0);
        tick();
        bus.instrReady = 1'b1;
        sample();
        tick();
        bus.instrReady = 1'b0;
        start = fires;
        sample();
        check("repop_req_valid", 32'(bus.memReqValid), 32'd1);
        tick();
        repeat (5) begin
            sample();
            tick();
        end
        check("repop_fires", 32'(fires - start), 32'd1);
        sample();
        check("repop_req_valid_after", 32'(bus.memReqValid), 32'd0);
        tick();
        bus.instrReady = 1'b1;
        repeat (4) tick();

        // Redirect with 3 requests in flight at latency 3.
        do_reset();
        mem_lat = 3;
        resetN = 1'b1;
        repeat (3) begin
            sample();
            tick();
        end
        bus.redirectValid = 1'b1;
        bus.redirectAddr = 16'h0100;
        sample();
        check("redirect_req_valid", 32'(bus.memReqValid), 32'd0);
        check("redirect_instr_valid", 32'(bus.instrValid), 32'd0);
        tick();
        bus.redirectValid = 1'b0;
        sample();
        check("newpath_req_valid", 32'(bus.memReqValid), 32'd1);
        check("newpath_req_addr", 32'(bus.memReqAddr), 32'h0100);
        for (int i = 4; i < 8; i++) begin
            if (i > 4) sample();
            check("flush_instr_valid", 32'(bus.instrValid), 32'd0);
            tick();
        end
        sample();
        check("newpath_instr_valid", 32'(bus.instrValid), 32'd1);
        check("newpath_instr_addr", 32'(bus.instrAddr), 32'h0100);
        check("newpath_opcode", 32'(opcode_of(bus.instruction)), 32'hB);
        tick();
        repeat (8) tick();

        // Fetch PC wrap.
        do_reset();
        mem_lat = 1;
        resetN = 1'b1;
        bus.redirectValid = 1'b1;
        bus.redirectAddr = 16'hFFFE;
        sample();
        check("wrap_redirect_req_valid", 32'(bus.memReqValid), 32'd0);
        tick();
        bus.redirectValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("wrap_req_addr", 32'(bus.memReqAddr), 32'(wrap_addrs[i]));
            tick();
        end

        // Memory not ready: request held stable, then halt withdraws it.
        bus.memReqReady = 1'b0;
        repeat (5) begin
            sample();
            check("stall_req_valid", 32'(bus.memReqValid), 32'd1);
            check("stall_req_addr", 32'(bus.memReqAddr), 32'h0002);
            tick();
        end
        bus.halt = 1'b1;
        #1;
        check("halt_req_valid", 32'(bus.memReqValid), 32'd0);
        sample();
        tick();
        bus.halt = 1'b0;
        bus.memReqReady = 1'b1;
        repeat (6) tick();

        // Asynchronous reset with two buffered entries.
        do_reset();
        bus.instrReady = 1'b0;
        resetN = 1'b1;
        repeat (3) begin
            sample();
            tick();
        end
        sample();
        check("pre_reset_instr_valid", 32'(bus.instrValid), 32'd1);
        #2;
        resetN = 1'b0;
        #1;
        check("async_instr_valid", 32'(bus.instrValid), 32'd0);
        check("async_req_valid", 32'(bus.memReqValid), 32'd0);
        tick();
        tick();
        resetN = 1'b1;
        sample();
        check("restart_req_valid", 32'(bus.memReqValid), 32'd1);
        check("restart_req_addr", 32'(bus.memReqAddr), 32'(RESET_PC));
        check("restart_instr_valid", 32'(bus.instrValid), 32'd0);
        tick();
        bus.instrReady = 1'b1;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
